// File: rtl/ctrl_decode_pipe.sv
// ID stage: decodes the opcode into the EX/MEM/WB control bundle, registers it into ID/EX,
// and interlocks read-after-write hazards and taken-branch squashes.
module ctrl_decode_pipe #(
    parameter int OPC_W  = 6,
    parameter int CMD_W  = 5,
    parameter int RA_W   = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] opcode,
    input  logic [RA_W-1:0]  src1,
    input  logic [RA_W-1:0]  src2,
    input  logic [RA_W-1:0]  dest,
    input  logic             ex_flush,
    output logic             out_valid,
    output logic [CMD_W-1:0] exec_cmd,
    output logic             is_imm,
    output logic             mem_r_en,
    output logic             mem_w_en,
    output logic             wb_en,
    output logic             st_or_bne,
    output logic             is_jmp,
    output logic             is_br,
    output logic             br_type,
    output logic [RA_W-1:0]  out_dest,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic            valid;
        logic [4:0]      cmd;
        logic            isImm;
        logic            memREn;
        logic            memWEn;
        logic            wbEn;
        logic            stOrBne;
        logic            isJmp;
        logic            isBr;
        logic            brType;
        logic            illegal;
        logic [RA_W-1:0] dest;
    } stage_t;

    stage_t          dec;
    stage_t          ex_d, ex_q;
    logic            memValid_q, memWb_q;
    logic [RA_W-1:0] memDest_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic            readsSrc1, readsSrc2;
    logic            upperSet;
    logic            hazard, stall;

    // Wider opcode fields are only legal when the extra bits are all zero.
    generate
        if (OPC_W > 6) begin : genUpper
            assign upperSet = |opcode[OPC_W-1:6];
        end else begin : genNoUpper
            assign upperSet = 1'b0;
        end
    endgenerate

    always_comb begin
        dec       = '0;
        readsSrc1 = 1'b0;
        readsSrc2 = 1'b0;
        dec.valid = 1'b1;
        dec.dest  = dest;
        if (upperSet) begin
            dec.illegal = 1'b1;
        end else begin
            case (opcode[5:0])
                6'd0: dec.illegal = 1'b0;
                6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12: begin
                    dec.wbEn  = 1'b1;
                    readsSrc1 = 1'b1;
                    readsSrc2 = 1'b1;
                    if (opcode[5:0] == 6'd1)      dec.cmd = 5'd0;
                    else if (opcode[5:0] == 6'd3) dec.cmd = 5'd1;
                    else                          dec.cmd = opcode[4:0] - 5'd3;
                end
                6'd32, 6'd33: begin
                    dec.cmd   = {4'd0, opcode[0]};
                    dec.isImm = 1'b1;
                    dec.wbEn  = 1'b1;
                    readsSrc1 = 1'b1;
                end
                6'd36: begin
                    dec.cmd    = 5'd16;
                    dec.isImm  = 1'b1;
                    dec.memREn = 1'b1;
                    dec.wbEn   = 1'b1;
                    readsSrc1  = 1'b1;
                end
                6'd37: begin
                    dec.cmd     = 5'd16;
                    dec.isImm   = 1'b1;
                    dec.memWEn  = 1'b1;
                    dec.stOrBne = 1'b1;
                    readsSrc1   = 1'b1;
                    readsSrc2   = 1'b1;
                end
                6'd40: begin
                    dec.cmd    = 5'd14;
                    dec.isImm  = 1'b1;
                    dec.isBr   = 1'b1;
                    dec.brType = 1'b1;
                    readsSrc1  = 1'b1;
                end
                6'd41: begin
                    dec.cmd     = 5'd15;
                    dec.isImm   = 1'b1;
                    dec.isBr    = 1'b1;
                    dec.stOrBne = 1'b1;
                    readsSrc1   = 1'b1;
                    readsSrc2   = 1'b1;
                end
                6'd42: begin
                    dec.cmd   = 5'd16;
                    dec.isImm = 1'b1;
                    dec.isJmp = 1'b1;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

    // With forwarding only a load in EX blocks; without it any writer in EX or MEM does.
    always_comb begin
        hazard = 1'b0;
        if (readsSrc1 && src1 != '0) begin
            if (ex_q.valid && ((FWD_EN != 0) ? ex_q.memREn : ex_q.wbEn) && ex_q.dest == src1)
                hazard = 1'b1;
            if ((FWD_EN == 0) && memValid_q && memWb_q && memDest_q == src1)
                hazard = 1'b1;
        end
        if (readsSrc2 && src2 != '0) begin
            if (ex_q.valid && ((FWD_EN != 0) ? ex_q.memREn : ex_q.wbEn) && ex_q.dest == src2)
                hazard = 1'b1;
            if ((FWD_EN == 0) && memValid_q && memWb_q && memDest_q == src2)
                hazard = 1'b1;
        end
        stall    = in_valid && !ex_flush && hazard;
        in_ready = !stall;

        ex_d = '0;
        if (in_valid && !ex_flush && !stall)
            ex_d = dec;

        cnt_d = cnt_q;
        if (stall && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q       <= '0;
            memValid_q <= 1'b0;
            memWb_q    <= 1'b0;
            memDest_q  <= '0;
            cnt_q      <= '0;
        end else begin
            ex_q       <= ex_d;
            memValid_q <= ex_q.valid;
            memWb_q    <= ex_q.wbEn;
            memDest_q  <= ex_q.dest;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = ex_q.valid;
    assign exec_cmd  = CMD_W'(ex_q.cmd);
    assign is_imm    = ex_q.isImm;
    assign mem_r_en  = ex_q.memREn;
    assign mem_w_en  = ex_q.memWEn;
    assign wb_en     = ex_q.wbEn;
    assign st_or_bne = ex_q.stOrBne;
    assign is_jmp    = ex_q.isJmp;
    assign is_br     = ex_q.isBr;
    assign br_type   = ex_q.brType;
    assign illegal   = ex_q.illegal;
    assign out_dest  = ex_q.dest;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: one forwarding instance (2-bit stall counter, 8-bit
// opcode) and one non-forwarding instance, both driven from the same stimulus.
module tb_ctrl_decode_pipe;

    localparam logic [7:0] OP_ADD  = 8'd1;
    localparam logic [7:0] OP_SUB  = 8'd3;
    localparam logic [7:0] OP_XOR  = 8'd5;
    localparam logic [7:0] OP_ADDI = 8'd32;
    localparam logic [7:0] OP_LD   = 8'd36;
    localparam logic [7:0] OP_ST   = 8'd37;
    localparam logic [7:0] OP_BEZ  = 8'd40;

    // {isImm, memREn, memWEn, wbEn, stOrBne, isJmp, isBr, brType, illegal}
    localparam logic [8:0] C_NONE  = 9'b000000000;
    localparam logic [8:0] C_RTYPE = 9'b000100000;
    localparam logic [8:0] C_IMMWB = 9'b100100000;
    localparam logic [8:0] C_LD    = 9'b110100000;
    localparam logic [8:0] C_ST    = 9'b101010000;
    localparam logic [8:0] C_BEZ   = 9'b100000110;
    localparam logic [8:0] C_BNE   = 9'b100010100;
    localparam logic [8:0] C_JMP   = 9'b100001000;
    localparam logic [8:0] C_ILL   = 9'b000000001;

    typedef struct packed {
        logic       v;
        logic [4:0] cmd;
        logic [8:0] ctrl;
        logic [4:0] dest;
    } obs_t;

    typedef struct {
        logic [7:0] opc;
        logic [4:0] dst;
        logic [4:0] cmd;
        logic [8:0] ctrl;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       inValid;
    logic [7:0] opcode;
    logic [4:0] src1, src2, dest;
    logic       exFlush;

    logic       inReadyF, outValidF, isImmF, memREnF, memWEnF, wbEnF, stOrBneF, isJmpF, isBrF, brTypeF, illegalF;
    logic [4:0] execCmdF, outDestF;
    logic [1:0] stallCntF;
    logic       inReadyN, outValidN, isImmN, memREnN, memWEnN, wbEnN, stOrBneN, isJmpN, isBrN, brTypeN, illegalN;
    logic [4:0] execCmdN, outDestN;
    logic [15:0] stallCntN;
    obs_t       obsF, obsN;

    int nCompared   = 0;
    int nMismatched = 0;
    vec_t vecs[16];

    ctrl_decode_pipe #(.OPC_W(8), .CMD_W(5), .RA_W(5), .FWD_EN(1), .CNT_W(2)) dutF (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyF), .opcode(opcode),
        .src1(src1), .src2(src2), .dest(dest), .ex_flush(exFlush), .out_valid(outValidF),
        .exec_cmd(execCmdF), .is_imm(isImmF), .mem_r_en(memREnF), .mem_w_en(memWEnF),
        .wb_en(wbEnF), .st_or_bne(stOrBneF), .is_jmp(isJmpF), .is_br(isBrF), .br_type(brTypeF),
        .out_dest(outDestF), .illegal(illegalF), .stall_cnt(stallCntF)
    );

    ctrl_decode_pipe #(.OPC_W(8), .CMD_W(5), .RA_W(5), .FWD_EN(0), .CNT_W(16)) dutN (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyN), .opcode(opcode),
        .src1(src1), .src2(src2), .dest(dest), .ex_flush(exFlush), .out_valid(outValidN),
        .exec_cmd(execCmdN), .is_imm(isImmN), .mem_r_en(memREnN), .mem_w_en(memWEnN),
        .wb_en(wbEnN), .st_or_bne(stOrBneN), .is_jmp(isJmpN), .is_br(isBrN), .br_type(brTypeN),
        .out_dest(outDestN), .illegal(illegalN), .stall_cnt(stallCntN)
    );

    assign obsF = {outValidF, execCmdF, isImmF, memREnF, memWEnF, wbEnF, stOrBneF, isJmpF,
                   isBrF, brTypeF, illegalF, outDestF};
    assign obsN = {outValidN, execCmdN, isImmN, memREnN, memWEnN, wbEnN, stOrBneN, isJmpN,
                   isBrN, brTypeN, illegalN, outDestN};

    function automatic obs_t mk(input logic v, input logic [4:0] cmd, input logic [8:0] ctrl,
                                input logic [4:0] d);
        return {v, cmd, ctrl, d};
    endfunction

    task automatic applyStimulus(input logic v, input logic [7:0] opc, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic [4:0] d, input logic fl);
        inValid = v;
        opcode  = opc;
        src1    = s1;
        src2    = s2;
        dest    = d;
        exFlush = fl;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b0;
        applyStimulus(1'b0, 8'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        vecs[0]  = '{OP_ADD, 5'd4,  5'd0,  C_RTYPE};
        vecs[1]  = '{OP_SUB, 5'd6,  5'd1,  C_RTYPE};
        vecs[2]  = '{8'd6,   5'd7,  5'd3,  C_RTYPE};
        vecs[3]  = '{8'd12,  5'd8,  5'd9,  C_RTYPE};
        vecs[4]  = '{OP_ADDI,5'd9,  5'd0,  C_IMMWB};
        vecs[5]  = '{8'd33,  5'd10, 5'd1,  C_IMMWB};
        vecs[6]  = '{OP_LD,  5'd11, 5'd16, C_LD};
        vecs[7]  = '{OP_ST,  5'd12, 5'd16, C_ST};
        vecs[8]  = '{OP_BEZ, 5'd13, 5'd14, C_BEZ};
        vecs[9]  = '{8'd41,  5'd14, 5'd15, C_BNE};
        vecs[10] = '{8'd42,  5'd15, 5'd16, C_JMP};
        vecs[11] = '{8'd0,   5'd0,  5'd0,  C_NONE};
        vecs[12] = '{8'd13,  5'd0,  5'd0,  C_ILL};
        vecs[13] = '{8'd2,   5'd0,  5'd0,  C_ILL};
        vecs[14] = '{8'hBF,  5'd0,  5'd0,  C_ILL};
        vecs[15] = '{8'hA1,  5'd0,  5'd0,  C_ILL};

        rst = 1'b0;
        applyStimulus(1'b0, 8'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #2;
        checkOutput("resetObsF", 32'(obsF), 32'd0);
        checkOutput("resetObsN", 32'(obsN), 32'd0);
        checkOutput("resetCntF", 32'(stallCntF), 32'd0);
        checkOutput("resetCntN", 32'(stallCntN), 32'd0);
        #1;
        rst = 1'b1;
        clockEdge();
        checkOutput("readyAfterReset", 32'(inReadyF), 32'd1);

        // Single ADD straight after reset.
        applyStimulus(1'b1, OP_ADD, 5'd2, 5'd3, 5'd4, 1'b0);
        #1;
        checkOutput("addReadyPre", 32'(inReadyF), 32'd1);
        clockEdge();
        checkOutput("addIssue", 32'(obsF), 32'(mk(1'b1, 5'd0, C_RTYPE, 5'd4)));
        applyStimulus(1'b0, 8'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        checkOutput("addReadyPost", 32'(inReadyF), 32'd1);

        // Decode table; sources at r0 so no vector can interlock with the previous one.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, vecs[i].opc, 5'd0, 5'd0, vecs[i].dst, 1'b0);
            #1;
            checkOutput($sformatf("vec%0dReady", i), 32'(inReadyF), 32'd1);
            clockEdge();
            checkOutput($sformatf("vec%0dOut", i), 32'(obsF),
                        32'(mk(1'b1, vecs[i].cmd, vecs[i].ctrl, vecs[i].dst)));
        end

        // Load-use with forwarding: exactly one bubble.
        doReset();
        applyStimulus(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b0);
        clockEdge();
        applyStimulus(1'b1, OP_ADD, 5'd5, 5'd6, 5'd8, 1'b0);
        #1;
        checkOutput("luReadyStall", 32'(inReadyF), 32'd0);
        clockEdge();
        checkOutput("luBubble", 32'(obsF), 32'd0);
        checkOutput("luCnt", 32'(stallCntF), 32'd1);
        checkOutput("luReadyAgain", 32'(inReadyF), 32'd1);
        clockEdge();
        checkOutput("luIssue", 32'(obsF), 32'(mk(1'b1, 5'd0, C_RTYPE, 5'd8)));

        // No forwarding: dependent right behind costs 2, two slots behind costs 1.
        doReset();
        applyStimulus(1'b1, OP_ADDI, 5'd1, 5'd0, 5'd7, 1'b0);
        clockEdge();
        applyStimulus(1'b1, OP_SUB, 5'd1, 5'd7, 5'd9, 1'b0);
        #1;
        checkOutput("rawReady0", 32'(inReadyN), 32'd0);
        clockEdge();
        checkOutput("rawBubble1", 32'(obsN), 32'd0);
        checkOutput("rawCnt1", 32'(stallCntN), 32'd1);
        checkOutput("rawReady1", 32'(inReadyN), 32'd0);
        clockEdge();
        checkOutput("rawBubble2", 32'(obsN), 32'd0);
        checkOutput("rawCnt2", 32'(stallCntN), 32'd2);
        checkOutput("rawReady2", 32'(inReadyN), 32'd1);
        clockEdge();
        checkOutput("rawIssue", 32'(obsN), 32'(mk(1'b1, 5'd1, C_RTYPE, 5'd9)));
        applyStimulus(1'b1, OP_XOR, 5'd1, 5'd2, 5'd3, 1'b0);
        #1;
        checkOutput("indepReady", 32'(inReadyN), 32'd1);
        clockEdge();
        checkOutput("indepIssue", 32'(obsN), 32'(mk(1'b1, 5'd2, C_RTYPE, 5'd3)));
        applyStimulus(1'b1, OP_ADDI, 5'd1, 5'd0, 5'd7, 1'b0);
        clockEdge();
        applyStimulus(1'b1, OP_ADD, 5'd1, 5'd2, 5'd10, 1'b0);
        clockEdge();
        applyStimulus(1'b1, OP_ADD, 5'd7, 5'd0, 5'd11, 1'b0);
        #1;
        checkOutput("memHazReady", 32'(inReadyN), 32'd0);
        clockEdge();
        checkOutput("memHazBubble", 32'(obsN), 32'd0);
        checkOutput("memHazReadyAfter", 32'(inReadyN), 32'd1);
        checkOutput("memHazCnt", 32'(stallCntN), 32'd3);

        // Taken branch squashes the presented ST.
        doReset();
        applyStimulus(1'b1, OP_BEZ, 5'd1, 5'd0, 5'd0, 1'b0);
        clockEdge();
        checkOutput("bezIssue", 32'(obsF), 32'(mk(1'b1, 5'd14, C_BEZ, 5'd0)));
        applyStimulus(1'b1, OP_ST, 5'd2, 5'd3, 5'd0, 1'b1);
        #1;
        checkOutput("flushReady", 32'(inReadyF), 32'd1);
        clockEdge();
        applyStimulus(1'b0, 8'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("flushBubble", 32'(obsF), 32'd0);
        checkOutput("flushCnt", 32'(stallCntF), 32'd0);
        clockEdge();
        checkOutput("flushStGone", 32'(obsF), 32'd0);

        // Flush wins over a load-use stall.
        applyStimulus(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b0);
        clockEdge();
        applyStimulus(1'b1, OP_ADD, 5'd5, 5'd0, 5'd8, 1'b1);
        #1;
        checkOutput("flushOverStallReady", 32'(inReadyF), 32'd1);
        clockEdge();
        applyStimulus(1'b0, 8'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("flushOverStallOut", 32'(obsF), 32'd0);
        checkOutput("flushOverStallCnt", 32'(stallCntF), 32'd0);

        // MEM shadow keeps the pre-flush writer visible.
        doReset();
        applyStimulus(1'b1, OP_ADDI, 5'd1, 5'd0, 5'd7, 1'b0);
        clockEdge();
        applyStimulus(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b1);
        clockEdge();
        applyStimulus(1'b1, OP_SUB, 5'd1, 5'd7, 5'd9, 1'b0);
        #1;
        checkOutput("shadowBubble", 32'(obsN), 32'd0);
        checkOutput("shadowStall", 32'(inReadyN), 32'd0);

        // Saturating 2-bit counter over four load-use stalls.
        doReset();
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b0);
            clockEdge();
            applyStimulus(1'b1, OP_ADD, 5'd5, 5'd6, 5'd8, 1'b0);
            clockEdge();
            clockEdge();
        end
        checkOutput("satCnt", 32'(stallCntF), 32'd3);

        // Asynchronous reset in the middle of a pending stall.
        applyStimulus(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b0);
        clockEdge();
        applyStimulus(1'b1, OP_ADD, 5'd5, 5'd6, 5'd8, 1'b0);
        #1;
        checkOutput("preResetStall", 32'(inReadyF), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("asyncObsF", 32'(obsF), 32'd0);
        checkOutput("asyncObsN", 32'(obsN), 32'd0);
        checkOutput("asyncCntF", 32'(stallCntF), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("asyncReadyAfter", 32'(inReadyF), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
